// File: rtl/debounce_scheduler_if.sv
// Event handshake bundle between the debounce scheduler and its consumer.
// The master side presents a held event with valid; the slave side returns ready.
// An event is consumed on any edge where valid and ready are both high.
interface debounce_scheduler_if #(
  parameter int CH_W = 2
);
  logic            o_Event_Valid;
  logic [CH_W-1:0] o_Event_Ch;
  logic            o_Event_Level;
  logic            i_Event_Ready;

  modport master (
    output o_Event_Valid,
    output o_Event_Ch,
    output o_Event_Level,
    input  i_Event_Ready
  );

  modport slave (
    input  o_Event_Valid,
    input  o_Event_Ch,
    input  o_Event_Level,
    output i_Event_Ready
  );
endinterface

// File: rtl/debounce_scheduler.sv
// Time-shared stable-count debouncer: one scan pointer visits one channel per scan strobe.
// Latency: a change commits on the DEBOUNCE_LIMIT-th consecutive differing visit (+2 clocks with sync).
// Backpressure: a committing strobe repeats every clock while an unconsumed event is held.
// Optional feature macro: DEBOUNCE_SCHED_SYNC_EN adds a 2-flop synchronizer on every i_Bouncy bit.
module debounce_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 20,
  parameter int SCAN_DIV       = 1,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1,
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic [NUM_CH-1:0]   i_Bouncy,
  output logic [NUM_CH-1:0]   o_Debounced,
  output logic [CH_W-1:0]     o_Scan_Ch,
  debounce_scheduler_if.master evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [CH_W-1:0]  PTR_LAST = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] w_In;
  logic [NUM_CH-1:0] r_Debounced;
  logic [CNT_W-1:0]  r_Cnt [NUM_CH];
  logic [CH_W-1:0]   r_Ptr;
  logic [PRE_W-1:0]  r_Pre;
  logic              r_Ev_Valid;
  logic [CH_W-1:0]   r_Ev_Ch;
  logic              r_Ev_Level;

`ifdef DEBOUNCE_SCHED_SYNC_EN
  logic [NUM_CH-1:0] r_Sync1;
  logic [NUM_CH-1:0] r_Sync2;

  // Two-flop synchronizer per input bit; scan logic only sees the second stage.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Sync1 <= '0;
      r_Sync2 <= '0;
    end else begin
      r_Sync1 <= i_Bouncy;
      r_Sync2 <= r_Sync1;
    end
  end

  assign w_In = r_Sync2;
`else
  assign w_In = i_Bouncy;
`endif

  logic w_Strobe;
  logic w_Bit;
  logic w_Diff;
  logic w_At_Last;
  logic w_Consume;
  logic w_Commit_Req;
  logic w_Stall;
  logic w_Commit;

  assign w_Strobe     = (r_Pre == PRE_LAST);
  assign w_Bit        = w_In[r_Ptr];
  assign w_Diff       = (w_Bit != r_Debounced[r_Ptr]);
  assign w_At_Last    = (r_Cnt[r_Ptr] == CNT_LAST);
  assign w_Consume    = r_Ev_Valid & evt.i_Event_Ready;
  assign w_Commit_Req = w_Strobe & w_Diff & w_At_Last;
  // Only a strobe that would overwrite a still-held event is frozen.
  assign w_Stall      = w_Commit_Req & r_Ev_Valid & ~evt.i_Event_Ready;
  assign w_Commit     = w_Commit_Req & ~w_Stall;

  // Prescaler: wraps on each strobe, parks on the last value while stalled so the strobe repeats.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Pre <= '0;
    end else if (w_Stall) begin
      r_Pre <= r_Pre;
    end else if (w_Strobe) begin
      r_Pre <= '0;
    end else begin
      r_Pre <= r_Pre + 1'b1;
    end
  end

  // Scan pointer and per-channel stable counts, updated only for the visited channel.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Ptr       <= '0;
      r_Debounced <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_Cnt[i] <= '0;
      end
    end else if (w_Strobe && !w_Stall) begin
      if (!w_Diff || w_At_Last) begin
        r_Cnt[r_Ptr] <= '0;
      end else begin
        r_Cnt[r_Ptr] <= r_Cnt[r_Ptr] + 1'b1;
      end
      if (w_Commit) begin
        r_Debounced[r_Ptr] <= w_Bit;
      end
      r_Ptr <= (r_Ptr == PTR_LAST) ? '0 : r_Ptr + 1'b1;
    end
  end

  // One-deep event register: a new commit loads even on the consume edge, so there is no bubble.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Ev_Valid <= 1'b0;
      r_Ev_Ch    <= '0;
      r_Ev_Level <= 1'b0;
    end else if (w_Commit) begin
      r_Ev_Valid <= 1'b1;
      r_Ev_Ch    <= r_Ptr;
      r_Ev_Level <= w_Bit;
    end else if (w_Consume) begin
      r_Ev_Valid <= 1'b0;
    end
  end

  assign o_Debounced       = r_Debounced;
  assign o_Scan_Ch         = r_Ptr;
  assign evt.o_Event_Valid = r_Ev_Valid;
  assign evt.o_Event_Ch    = r_Ev_Ch;
  assign evt.o_Event_Level = r_Ev_Level;

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
Time-shared debounce engine for NUM_CH switch/button inputs. A single scan pointer visits one channel per scan strobe and applies the stable-count debounce rule to that channel. Each channel has its own small count register and debounced state. Every committed level change is reported through a one-deep event register with a valid/ready handshake. The block sits between raw board buttons/switches and the user logic that consumes button events.

Parameters:
NUM_CH, 4, number of bouncy input channels (>=2)
DEBOUNCE_LIMIT, 20, number of consecutive visits an input must differ from its debounced state before the change commits (>=2)
SCAN_DIV, 1, clocks per scan strobe (>=1); a channel is visited every NUM_CH*SCAN_DIV clocks when not stalled

Ports:
i_Clk  input  1  system clock
i_Rst_L  input  1  synchronous active-low reset
i_Bouncy  input  NUM_CH  raw switch/button inputs, bit n = channel n
o_Debounced  output  NUM_CH  debounced level per channel
o_Event_Valid  output  1  event register holds an unconsumed event
o_Event_Ch  output  max(1,$clog2(NUM_CH))  channel index of the held event
o_Event_Level  output  1  new debounced level of the held event
i_Event_Ready  input  1  consumer accepts the event on a cycle where valid&ready
o_Scan_Ch  output  max(1,$clog2(NUM_CH))  current scan pointer (debug)

Behaviour:
- Clock and reset: single clock i_Clk. Reset is synchronous and active-low on i_Rst_L.
- Reset values (when i_Rst_L=0 at a clock edge): o_Debounced=0, all channel counts=0, scan pointer=0, prescaler=0, o_Event_Valid=0, o_Event_Ch=0, o_Event_Level=0.
- Reset mid-operation: any pending event and any partial counts are discarded.
- Count width: max(1,$clog2(DEBOUNCE_LIMIT)) bits per channel. Counts never exceed DEBOUNCE_LIMIT-1.
- Prescaler: counts 0..SCAN_DIV-1. A scan strobe occurs on the clock where prescaler==SCAN_DIV-1; the prescaler then wraps to 0. With SCAN_DIV=1, a strobe occurs every clock.
- On a strobe, let p = pointer, d = (i_Bouncy[p] != o_Debounced[p]):
  - d and cnt[p] < DEBOUNCE_LIMIT-1: cnt[p] <= cnt[p]+1.
  - d and cnt[p] == DEBOUNCE_LIMIT-1: commit.
    - o_Debounced[p] <= i_Bouncy[p] and cnt[p] <= 0.
    - Load event: Ch=p, Level=i_Bouncy[p], Valid=1.
  - !d: cnt[p] <= 0, with no update and no event, even when the count is at its limit.
  - The pointer advances p -> p+1, wrapping from NUM_CH-1 to 0.
- Commit timing: a change commits on the DEBOUNCE_LIMIT-th consecutive differing visit. o_Debounced[p] and o_Event_Valid rise on the same edge.
- Handshake: the event is consumed on any edge where o_Event_Valid=1 and i_Event_Ready=1. When consumed with no new commit, Valid <= 0. Event outputs are held stable while Valid=1 and Ready=0.
- Stall: if a strobe would commit while Valid=1 and Ready=0, nothing happens on that strobe:
  - no commit, cnt[p] unchanged, pointer not advanced;
  - the prescaler holds at SCAN_DIV-1, so the strobe repeats each clock until Ready.
  - Non-committing strobes are never stalled.
- Simultaneous consume and commit (Valid=1, Ready=1, commit on the same edge): the old event is accepted and the new event loads with no bubble; Valid stays 1.
- Event loss: none. Events are delivered in commit order.
- i_Bouncy is sampled only at the visited channel on its strobe. Unvisited channels are unaffected.

Optional Feature:
DEBOUNCE_SCHED_SYNC_EN
- Defined: each i_Bouncy bit passes through a 2-flop synchronizer, and the scan logic uses the synchronized value. This adds 2 clocks of input latency; the synchronizer flops reset to 0.
- Undefined: i_Bouncy feeds the scan logic directly, and the source must already be synchronous to i_Clk.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: i_Rst_L=0 for 3 clocks with i_Bouncy=4'b1111 -> o_Debounced=0, o_Event_Valid=0, o_Scan_Ch=0. Release reset -> pointer counts 0,1,2,3,0.
- Clean press (NUM_CH=4, LIMIT=4, SCAN_DIV=1, Ready=1): i_Bouncy[2] 0->1 held -> o_Debounced[2]=1 on ch2's 4th visit, 13-16 clocks after the change. One cycle of Valid=1, Ch=2, Level=1. No other channel changes.
- Bounce rejection (LIMIT=4): i_Bouncy[1] toggles every 6 clocks for 200 clocks -> o_Debounced[1] stays 0 and no event. Hold i_Bouncy[1]=1 steady -> event Ch=1, Level=1 once.
- Backpressure: Ready=0; ch0 and ch3 both go high -> ch0 event held with Ch=0, pointer stalls at 3, o_Debounced[3]=0. Raise Ready -> ch0 consumed and ch3 event loads on the same edge; then Ch=3, Level=1; exactly 2 events total.
- Reset mid-count: ch0 differing for 3 of 4 visits, pulse i_Rst_L=0 for one clock -> count cleared. ch0 requires 4 fresh visits to commit after reset.
- Prescaled scan (SCAN_DIV=3, NUM_CH=4, LIMIT=2): ch0 steps to 1 -> commit on ch0's 2nd differing visit, visits 12 clocks apart. Check o_Scan_Ch changes every 3 clocks.
